// File: rtl/rs232_pkg.sv
// Shared constants and parser state encoding for the RS-232 command controller.
package rs232_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] OP_WR     = 8'h01;
    localparam logic [7:0] OP_RD     = 8'h02;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_EXEC,
        S_RDLAT,
        S_RESP
    } state_t;

endpackage

// File: rtl/rs232_rx_capture.sv
// Byte-capture handshake toward the deserializer: one capture per rx_req
// assertion, re-armed only after rx_req has been seen low.
module rs232_rx_capture (
    input  logic clk,
    input  logic rst,
    input  logic rx_req,
    input  logic cap_en,
    output logic cap,
    output logic rx_ack
);

    logic armed;

    // The parser consumes rx_data directly in the capture cycle.
    assign cap = rx_req && armed && cap_en;

    // Armed flag and the registered one-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed  <= 1'b1;
            rx_ack <= 1'b0;
        end else begin
            rx_ack <= cap;
            if (!rx_req)
                armed <= 1'b1;
            else if (cap)
                armed <= 1'b0;
        end
    end

endmodule

// File: rtl/rs232_cmd_ctrl.sv
// Packet parser, register-bus sequencer and response driver sitting between
// the byte deserializer and the byte serializer.
module rs232_cmd_ctrl
    import rs232_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_req,
    output logic              rx_ack,
    output logic [7:0]        tx_data,
    output logic              tx_req,
    input  logic              tx_ack,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_d;
    logic          cap, cap_en, parsing, timeout;
    logic          opc_ok, csum_ok, nak;
    logic [7:0]    opc_q, addr_q, data_q;
    logic [TW-1:0] to_cnt;

    // No capture while executing or responding: the deserializer holds its byte.
    assign cap_en  = (state == S_IDLE) || parsing;
    assign parsing = (state == S_OPC) || (state == S_ADDR) ||
                     (state == S_DATA) || (state == S_CSUM);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout = parsing && !cap && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign opc_ok  = (opc_q == OP_WR) || (opc_q == OP_RD);
    assign csum_ok = rx_data == (opc_q ^ addr_q ^ ((opc_q == OP_WR) ? data_q : 8'h00));
    // In EXEC, absence of both strobes means the packet was rejected.
    assign nak     = (state == S_EXEC) && !reg_wr && !reg_rd;
    assign busy    = (state != S_IDLE);

    rs232_rx_capture u_cap (
        .clk    (clk),
        .rst    (rst),
        .rx_req (rx_req),
        .cap_en (cap_en),
        .cap    (cap),
        .rx_ack (rx_ack)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state: walk the packet fields, then execute and respond.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (cap && rx_data == SYNC_BYTE) state_d = S_OPC;
            S_OPC:   if (cap) state_d = S_ADDR;
            S_ADDR:  if (cap) state_d = (opc_q == OP_WR) ? S_DATA : S_CSUM;
            S_DATA:  if (cap) state_d = S_CSUM;
            S_CSUM:  if (cap) state_d = S_EXEC;
            S_EXEC:  state_d = reg_rd ? S_RDLAT : S_RESP;
            S_RDLAT: state_d = S_RESP;
            S_RESP:  if (tx_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
    end

    // Inter-byte timeout counter, live only while inside a packet.
    always_ff @(posedge clk) begin
        if (rst || !parsing || cap || timeout) to_cnt <= '0;
        else                                   to_cnt <= to_cnt + 1'b1;
    end

    // Packet field latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            opc_q  <= 8'h00;
            addr_q <= 8'h00;
            data_q <= 8'h00;
        end else if (cap) begin
            if (state == S_OPC)  opc_q  <= rx_data;
            if (state == S_ADDR) addr_q <= rx_data;
            if (state == S_DATA) data_q <= rx_data;
        end
    end

    // Register bus: address/data and strobes launched as the checksum lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            if (state == S_CSUM && cap) begin
                reg_addr  <= ADDR_W'(addr_q);
                reg_wdata <= data_q;
                reg_wr    <= opc_ok && csum_ok && (opc_q == OP_WR);
                reg_rd    <= opc_ok && csum_ok && (opc_q == OP_RD);
            end
        end
    end

    // Response byte and request, held until the serializer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_req  <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            case (state)
                S_EXEC: if (!reg_rd) begin
                    tx_req  <= 1'b1;
                    tx_data <= reg_wr ? RSP_ACK : RSP_NAK;
                end
                S_RDLAT: begin
                    tx_req  <= 1'b1;
                    tx_data <= reg_rdata;
                end
                S_RESP: if (tx_ack) tx_req <= 1'b0;
                default: ;
            endcase
        end
    end

    // Saturating error counter: rejected packets and aborted packets.
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= 8'h00;
        else if ((nak || timeout) && err_count != 8'hFF)
            err_count <= err_count + 8'h01;
    end

endmodule

// File: tb/tb_rs232_cmd_ctrl.sv
// Directed bench for rs232_cmd_ctrl with a packet-level reference model and a
// per-cycle compare process.
module tb_rs232_cmd_ctrl;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_req = 1'b0;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ack = 1'b0;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, reg_rd;
    logic [7:0] err_count;
    logic       busy;

    always #5 clk = ~clk;

    rs232_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_req(rx_req), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_req(tx_req), .tx_ack(tx_ack),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .err_count(err_count), .busy(busy)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Register bus slave: read data one cycle after the read strobe.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (reg_wr) mem[reg_addr] = reg_wdata;
        if (reg_rd) reg_rdata <= mem[reg_addr];
    end

    // Packet-level reference model.
    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [7:0] rsp; int err; int kind; } rsp_t;
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    rsp_t       exp_rsp[$];
    logic [7:0] model_mem [256];
    int         model_err = 0;

    // Compare process state.
    int         acks = 0, cyc = 0, wr_cyc = -10, rd_cyc = -10;
    logic       prev_txreq = 1'b0;
    logic [7:0] held = 8'h00;
    wr_t        w_tmp;
    rsp_t       r_tmp;
    logic [7:0] a_tmp;

    always @(posedge clk) cyc++;

    // Check DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_ack) acks++;
            if (reg_wr) begin
                if (exp_wr.size() == 0) chk("unexpected_reg_wr", 1, 0);
                else begin
                    w_tmp = exp_wr.pop_front();
                    chk("wr_addr", reg_addr, w_tmp.a);
                    chk("wr_data", reg_wdata, w_tmp.d);
                end
                wr_cyc = cyc;
            end
            if (reg_rd) begin
                if (exp_rd.size() == 0) chk("unexpected_reg_rd", 1, 0);
                else begin
                    a_tmp = exp_rd.pop_front();
                    chk("rd_addr", reg_addr, a_tmp);
                end
                rd_cyc = cyc;
            end
            if (tx_req && !prev_txreq) begin
                if (exp_rsp.size() == 0) chk("unexpected_tx_req", 1, 0);
                else begin
                    r_tmp = exp_rsp.pop_front();
                    chk("tx_data", tx_data, r_tmp.rsp);
                    chk("err_at_rsp", err_count, r_tmp.err);
                    if (r_tmp.kind == 1) chk("wr_latency", cyc - wr_cyc, 1);
                    if (r_tmp.kind == 2) chk("rd_latency", cyc - rd_cyc, 2);
                end
                held = tx_data;
            end else if (tx_req) begin
                chk("tx_data_stable", tx_data, held);
            end
            if (tx_req) chk("no_rx_ack_in_resp", rx_ack, 0);
        end
        prev_txreq = tx_req;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Deserializer model: present a byte, wait for the ack, then drop req a cycle.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data = b;
        rx_req  = 1'b1;
        while (!rx_ack && t < 200) begin tick(); t++; end
        if (!rx_ack) chk("rx_ack_wait", 0, 1);
        rx_req = 1'b0;
        tick();
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] cs);
        logic [7:0] exp_cs;
        rsp_t r;
        exp_cs = op ^ a ^ ((op == 8'h01) ? d : 8'h00);
        if ((op == 8'h01 || op == 8'h02) && cs == exp_cs) begin
            if (op == 8'h01) begin
                exp_wr.push_back('{a, d});
                model_mem[a] = d;
                r = '{8'h06, model_err, 1};
            end else begin
                exp_rd.push_back(a);
                r = '{model_mem[a], model_err, 2};
            end
        end else begin
            model_err = (model_err < 255) ? model_err + 1 : 255;
            r = '{8'h15, model_err, 0};
        end
        exp_rsp.push_back(r);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(a);
        if (op == 8'h01) send_byte(d);
        send_byte(cs);
    endtask

    task automatic wait_tx(output logic [7:0] d);
        int t = 0;
        while (!tx_req && t < 50) begin tick(); t++; end
        if (!tx_req) chk("tx_req_wait", 0, 1);
        d = tx_data;
    endtask

    task automatic ack_tx();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk("tx_req_drop", tx_req, 0);
        chk("idle_after_resp", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int a0, t;
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 8'(i);
            model_mem[i] = 8'(i);
        end
        mem[8'h20]       = 8'h5A;
        model_mem[8'h20] = 8'h5A;

        // Reset state
        tick(3);
        chk("rst_rx_ack", rx_ack, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_reg_rd", reg_rd, 0);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_wdata", reg_wdata, 8'h00);
        chk("rst_err", err_count, 8'h00);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        // Good write
        a0 = acks;
        send_pkt(8'h01, 8'h10, 8'h3C, 8'h2D);
        wait_tx(d);
        chk("t1_rsp", d, 8'h06);
        tick(2);
        ack_tx();
        chk("t1_acks", acks - a0, 5);
        chk("t1_err", err_count, 0);
        chk("t1_mem", mem[8'h10], 8'h3C);

        // Good read, with a byte pending during the response
        send_pkt(8'h02, 8'h20, 8'h00, 8'h22);
        wait_tx(d);
        chk("t2_rsp", d, 8'h5A);
        a0 = acks;
        rx_data = 8'h00;
        rx_req  = 1'b1;
        tick(4);
        chk("t2_no_ack", acks - a0, 0);
        chk("t2_busy", busy, 1);
        ack_tx();
        t = 0;
        while (!rx_ack && t < 20) begin tick(); t++; end
        chk("t2_late_ack", rx_ack, 1);
        rx_req = 1'b0;
        tick();
        chk("t2_discard_idle", busy, 0);

        // Bad checksum
        send_pkt(8'h01, 8'h10, 8'h3C, 8'h00);
        wait_tx(d);
        chk("t3_rsp", d, 8'h15);
        ack_tx();
        chk("t3_err", err_count, 1);
        chk("t3_mem_kept", mem[8'h10], 8'h3C);

        // Garbage then a valid write
        a0 = acks;
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("t4_garbage_acks", acks - a0, 2);
        chk("t4_garbage_idle", busy, 0);
        chk("t4_garbage_err", err_count, 1);
        send_pkt(8'h01, 8'h33, 8'h77, 8'h45);
        wait_tx(d);
        chk("t4_rsp", d, 8'h06);
        ack_tx();
        chk("t4_mem", mem[8'h33], 8'h77);

        // Timeout mid-packet, then a good read
        send_byte(8'hA5);
        send_byte(8'h01);
        tick(TO - 10);
        chk("t5_busy_before", busy, 1);
        tick(20);
        chk("t5_busy_after", busy, 0);
        model_err = (model_err < 255) ? model_err + 1 : 255;
        chk("t5_err", err_count, 2);
        chk("t5_err_model", err_count, model_err);
        chk("t5_no_tx", tx_req, 0);
        send_pkt(8'h02, 8'h33, 8'h00, 8'h31);
        wait_tx(d);
        chk("t5_rsp", d, 8'h77);
        ack_tx();

        // Bad opcode is consumed at read length and rejected
        send_pkt(8'h03, 8'h44, 8'h00, 8'h47);
        wait_tx(d);
        chk("t6_badop_rsp", d, 8'h15);
        ack_tx();
        chk("t6_badop_err", err_count, 3);

        // Reset during a response
        send_pkt(8'h01, 8'h55, 8'hAA, 8'hFE);
        wait_tx(d);
        chk("t7_pre_rst_txreq", tx_req, 1);
        rst = 1'b1;
        tick();
        chk("t7_rst_txreq", tx_req, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_err", err_count, 0);
        rst = 1'b0;
        model_err = 0;
        exp_wr.delete();
        exp_rd.delete();
        exp_rsp.delete();
        tick(2);

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            send_pkt(8'h01, 8'(i), 8'h00, ~(8'h01 ^ 8'(i)));
            wait_tx(d);
            ack_tx();
        end
        chk("t8_err_sat", err_count, 8'hFF);
        send_pkt(8'h02, 8'h00, 8'h00, 8'h00);
        wait_tx(d);
        ack_tx();
        chk("t8_err_hold", err_count, 8'hFF);

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs232_cmd_ctrl.md
# rs232_cmd_ctrl

Command controller between the `rs232_des` byte deserializer and a simple register bus, plus a byte serializer for responses. Consumes received bytes via the `rx_req`/`rx_ack` handshake, parses fixed-format read/write packets, checks them, issues single-cycle register accesses, and returns a one-byte response (ACK, NAK or read data) over the `tx_req`/`tx_ack` handshake. It sequences the serial datapath; it does no bit-level timing.

## Interface
- `TIMEOUT_CYCLES`, 1_000_000: max `clk` cycles between bytes inside a packet before abort (about 10 ms at 100 MHz).
- `ADDR_W`, 8: register address width; the low `ADDR_W` bits of the address byte are used.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte from the deserializer.
- `rx_req`  in  1  received byte valid; level.
- `rx_ack`  out  1  one-cycle pulse: byte consumed.
- `tx_data`  out  8  response byte to the serializer.
- `tx_req`  out  1  response valid; held until `tx_ack`.
- `tx_ack`  in  1  one-cycle pulse from the serializer: byte taken.
- `reg_addr`  out  ADDR_W  register address.
- `reg_wdata`  out  8  write data.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid exactly 1 cycle after `reg_rd`.
- `err_count`  out  8  saturating count of NAKs plus timeouts.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Packet format: `0xA5`, opcode, addr, [data if write], csum.
  - Opcode `0x01` is write; `0x02` is read.
  - csum = opcode ^ addr ^ data for a write, opcode ^ addr for a read.
- Byte capture: when `rx_req`=1 and the rx-armed flag is set, latch `rx_data`, pulse `rx_ack` for 1 cycle and clear armed. Armed sets again on any cycle with `rx_req`=0.
- FSM states: IDLE, OPC, ADDR, DATA, CSUM, EXEC, RDLAT, RESP.
  - IDLE: a byte equal to `0xA5` goes to OPC. Any other byte is acked and discarded, with no error.
  - OPC: any byte goes to ADDR. An opcode other than 0x01/0x02 is flagged bad; the packet is still consumed to csum length, which counts as a read.
  - ADDR: goes to DATA if the opcode is 0x01, else to CSUM.
  - DATA → CSUM.
  - CSUM: goes to EXEC.
  - EXEC, packet good: write pulses `reg_wr` and sets response `0x06`; read pulses `reg_rd` and goes to RDLAT. Bad csum or bad opcode: response `0x15`, `err_count`+1, no register strobe.
  - RDLAT: response = `reg_rdata`, then RESP.
  - RESP: drive `tx_data` and `tx_req`=1 until a cycle with `tx_ack`=1. In that cycle drop `tx_req` and go to IDLE.
- Timeout: in OPC/ADDR/DATA/CSUM, a counter clears on every captured byte. On reaching `TIMEOUT_CYCLES`-1 without a byte: go to IDLE, `err_count`+1, no response.
- No new bytes are captured in EXEC/RDLAT/RESP; `rx_ack` stays 0 there and the deserializer holds its byte.
- `err_count` saturates at 255; it never wraps.
- Simultaneous events:
  - A timeout and a byte capture in the same cycle: the byte wins.
  - `tx_ack` while `tx_req`=0 is ignored.

## Timing
- Reset values: `rx_ack`=0, `tx_req`=0, `tx_data`=0x00, `reg_wr`=0, `reg_rd`=0, `reg_addr`=0, `reg_wdata`=0, `err_count`=0, `busy`=0, FSM=IDLE, armed=1, timeout counter=0.
- `rst` asserted mid-packet or mid-response forces the reset state on the next edge. Any partial packet is dropped, and `tx_req` falls even without `tx_ack`.
- `rx_ack` goes high the cycle after `rx_req` is sampled high with armed set.
- Write latency: csum captured at cycle N → `reg_wr` at N+1 → `tx_req` rises at N+2.
- Read latency: `reg_rd` at N+1 → `reg_rdata` sampled at N+2 → `tx_req` rises at N+3.
- `reg_addr` and `reg_wdata` are stable from the EXEC cycle until the next packet's EXEC.
- `tx_data` is stable for as long as `tx_req`=1.

## Structure
- Shared package `rs232_pkg`:
  - Constants `SYNC_BYTE`=0xA5, `OP_WR`=0x01, `OP_RD`=0x02, `RSP_ACK`=0x06, `RSP_NAK`=0x15.
  - State enum/localparams.
- Optional sub-module `rs232_rx_capture`: armed flag, `rx_ack` pulse and byte latch. The parser FSM, timeout counter and error counter stay in the top module.

## Test plan
- Write `A5 01 10 3C 2D` → one `reg_wr` pulse with addr=0x10, wdata=0x3C; `tx_data`=0x06; five `rx_ack` pulses; `err_count`=0.
- Read `A5 02 20 22`, with `reg_rdata`=0x5A at the sample cycle → `reg_rd` pulse with addr=0x20, `tx_data`=0x5A; then `rx_req` high before `tx_ack` → no `rx_ack` until RESP completes.
- Bad csum `A5 01 10 3C 00` → no `reg_wr`; `tx_data`=0x15; `err_count`=1.
- Garbage `00 FF` then a valid write → garbage acked and discarded, no error; write executes normally.
- `A5 01`, then silence for `TIMEOUT_CYCLES` → IDLE, `err_count`+1, `tx_req` stays 0; a following valid read succeeds.
- `rst` pulsed while `tx_req`=1 → `tx_req`=0 and `busy`=0 next cycle; 256 NAKs → `err_count` holds at 255.
